// File: rtl/bridge_mdev_pkg.sv
// Shared constants and FSM state type for the multi-device system bridge.
package bridge_mdev_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned CTL_MASK   = 0;
    localparam int unsigned CTL_STATUS = 1;

    localparam logic [31:0] BUS_ERR_DATA = 32'h0;

endpackage

// File: rtl/bridge_mdev_if.sv
// CPU data port, peripheral strobes and interrupt lines of the system bridge.
interface bridge_mdev_if #(
    parameter int unsigned NUM_DEV = 4,
    parameter int unsigned OFF_W   = 2
);

    logic [29:0]           pr_addr;
    logic [31:0]           pr_wd;
    logic                  pr_we;
    logic                  pr_re;
    logic [31:0]           pr_rd;
    logic                  pr_ready;
    logic                  pr_err;
    logic [OFF_W-1:0]      dev_addr;
    logic [31:0]           dev_wd;
    logic [NUM_DEV-1:0]    dev_we;
    logic [NUM_DEV-1:0]    dev_re;
    logic [32*NUM_DEV-1:0] dev_rd;
    logic [NUM_DEV-1:0]    dev_ack;
    logic [NUM_DEV-1:0]    dev_irq;
    logic [NUM_DEV-1:0]    hw_int;

    // Environment view: CPU plus peripherals.
    modport master (
        output pr_addr, pr_wd, pr_we, pr_re, dev_rd, dev_ack, dev_irq,
        input  pr_rd, pr_ready, pr_err, dev_addr, dev_wd, dev_we, dev_re, hw_int
    );

    // Bridge view.
    modport slave (
        input  pr_addr, pr_wd, pr_we, pr_re, dev_rd, dev_ack, dev_irq,
        output pr_rd, pr_ready, pr_err, dev_addr, dev_wd, dev_we, dev_re, hw_int
    );

endinterface

// File: rtl/bridge_mdev_decode.sv
// Address decoder: maps a CPU word address onto device windows 0..NUM_DEV-1
// and the control window at index NUM_DEV.
module bridge_mdev_decode #(
    parameter int unsigned NUM_DEV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned OFF_W     = 2,
    parameter int unsigned IDX_W     = $clog2(NUM_DEV + 1)
) (
    input  logic [29:0]      pr_addr,
    output logic [NUM_DEV:0] dev_hit,
    output logic [IDX_W-1:0] idx,
    output logic [OFF_W-1:0] off
);

    localparam int unsigned     WIN_W = 30 - OFF_W;
    localparam logic [WIN_W-1:0] WIN0 = BASE_ADDR[31:OFF_W+2];

    always_comb begin
        dev_hit = '0;
        idx     = '0;
        for (int unsigned i = 0; i <= NUM_DEV; i++) begin
            if (pr_addr[29:OFF_W] == WIN0 + WIN_W'(i)) begin
                dev_hit[i] = 1'b1;
                idx        = IDX_W'(i);
            end
        end
    end

    assign off = pr_addr[OFF_W-1:0];

endmodule

// File: rtl/bridge_mdev.sv
// System bridge from the CPU data port to NUM_DEV peripherals with wait states,
// timeout errors and a masked interrupt aggregator.
module bridge_mdev
    import bridge_mdev_pkg::*;
#(
    parameter int unsigned NUM_DEV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned OFF_W     = 2,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CNT_W     = 5
) (
    input logic         clk,
    input logic         rst,
    bridge_mdev_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_DEV + 1);

    logic [NUM_DEV:0]   dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic [OFF_W-1:0]   dec_off;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               op_we_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_DEV-1:0] mask_q;
    logic [NUM_DEV-1:0] irq_sync_q;

    logic               sel_ack;
    logic [31:0]        sel_rd;
    logic               req;
    logic               ctl_mask_hit;
    logic               ctl_status_hit;

    bridge_mdev_decode #(
        .NUM_DEV   (NUM_DEV),
        .BASE_ADDR (BASE_ADDR),
        .OFF_W     (OFF_W),
        .IDX_W     (IDX_W)
    ) u_decode (
        .pr_addr (bus.pr_addr),
        .dev_hit (dec_hit),
        .idx     (dec_idx),
        .off     (dec_off)
    );

    assign req            = bus.pr_we | bus.pr_re;
    assign ctl_mask_hit   = dec_hit[NUM_DEV] && (dec_off == OFF_W'(CTL_MASK));
    assign ctl_status_hit = dec_hit[NUM_DEV] && (dec_off == OFF_W'(CTL_STATUS));

    // Only the latched device's ack and read data are visible to the FSM.
    always_comb begin
        sel_ack = 1'b0;
        sel_rd  = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack = bus.dev_ack[i];
                sel_rd  = bus.dev_rd[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            op_we_q      <= 1'b0;
            cnt_q        <= '0;
            mask_q       <= '0;
            irq_sync_q   <= '0;
            bus.pr_rd    <= '0;
            bus.pr_ready <= 1'b0;
            bus.pr_err   <= 1'b0;
            bus.dev_addr <= '0;
            bus.dev_wd   <= '0;
            bus.dev_we   <= '0;
            bus.dev_re   <= '0;
            bus.hw_int   <= '0;
        end else begin
            irq_sync_q   <= bus.dev_irq;
            bus.hw_int   <= irq_sync_q & mask_q;
            bus.pr_ready <= 1'b0;
            bus.pr_err   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req && |dec_hit[NUM_DEV-1:0]) begin
                        bus.dev_addr <= dec_off;
                        bus.dev_wd   <= bus.pr_wd;
                        idx_q        <= dec_idx;
                        op_we_q      <= bus.pr_we;
                        cnt_q        <= '0;
                        bus.dev_we   <= bus.pr_we ? dec_hit[NUM_DEV-1:0] : '0;
                        bus.dev_re   <= bus.pr_we ? '0 : dec_hit[NUM_DEV-1:0];
                        state_q      <= StWait;
                    end else if (req) begin
                        bus.pr_ready <= 1'b1;
                        state_q      <= StDone;
                        if (ctl_mask_hit) begin
                            if (bus.pr_we) begin
                                mask_q    <= bus.pr_wd[NUM_DEV-1:0];
                                bus.pr_rd <= '0;
                            end else begin
                                bus.pr_rd <= {{(32 - NUM_DEV){1'b0}}, mask_q};
                            end
                        end else if (ctl_status_hit && !bus.pr_we) begin
                            bus.pr_rd <= {{(32 - NUM_DEV){1'b0}}, irq_sync_q};
                        end else begin
                            bus.pr_rd  <= BUS_ERR_DATA;
                            bus.pr_err <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    // An ack arriving on the timeout cycle still completes cleanly.
                    if (sel_ack) begin
                        bus.pr_rd    <= op_we_q ? '0 : sel_rd;
                        bus.pr_ready <= 1'b1;
                        bus.dev_we   <= '0;
                        bus.dev_re   <= '0;
                        state_q      <= StDone;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        bus.pr_rd    <= BUS_ERR_DATA;
                        bus.pr_err   <= 1'b1;
                        bus.pr_ready <= 1'b1;
                        bus.dev_we   <= '0;
                        bus.dev_re   <= '0;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_mdev.sv
// Directed bench for bridge_mdev: device reads/writes, timeout, decode errors,
// interrupt masking and reset abandoning a transfer.
module tb_bridge_mdev;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bridge_mdev_if #(.NUM_DEV(4), .OFF_W(2)) bus ();

    bridge_mdev #(
        .NUM_DEV   (4),
        .BASE_ADDR (32'h0000_7F00),
        .OFF_W     (2),
        .TIMEOUT   (16),
        .CNT_W     (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.pr_addr = '0;
        bus.pr_wd   = '0;
        bus.pr_we   = 1'b0;
        bus.pr_re   = 1'b0;
        bus.dev_rd  = '0;
        bus.dev_ack = '0;
        bus.dev_irq = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_ready", bus.pr_ready, 0);
        check("rst_err", bus.pr_err, 0);
        check("rst_rd", bus.pr_rd, 0);
        check("rst_we", bus.dev_we, 0);
        check("rst_re", bus.dev_re, 0);
        check("rst_int", bus.hw_int, 0);
        check("rst_addr", bus.dev_addr, 0);
        check("rst_wd", bus.dev_wd, 0);

        // Read dev 1 offset 2, ack on third WAIT cycle; a foreign ack is ignored.
        bus.dev_rd[63:32] = 32'h1234_5678;
        bus.dev_rd[31:0]  = 32'hDEAD_BEEF;
        bus.pr_addr = 30'h1FC6;
        bus.pr_re   = 1'b1;
        tick();
        check("t1_re_c1", bus.dev_re, 4'b0010);
        check("t1_addr", bus.dev_addr, 2);
        check("t1_we", bus.dev_we, 0);
        bus.dev_ack = 4'b0001;
        tick();
        check("t1_re_c2", bus.dev_re, 4'b0010);
        check("t1_busy", bus.pr_ready, 0);
        bus.dev_ack = 4'b0000;
        tick();
        check("t1_re_c3", bus.dev_re, 4'b0010);
        bus.dev_ack = 4'b0010;
        tick();
        check("t1_ready", bus.pr_ready, 1);
        check("t1_rd", bus.pr_rd, 32'h1234_5678);
        check("t1_err", bus.pr_err, 0);
        check("t1_re_off", bus.dev_re, 0);
        bus.dev_ack = '0;
        bus.pr_re   = 1'b0;
        tick();
        check("t1_pulse", bus.pr_ready, 0);

        // Read dev 2 with no ack: 16 WAIT cycles then an error completion.
        bus.pr_addr = 30'h1FC8;
        bus.pr_re   = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            check("t3_re", bus.dev_re, 4'b0100);
            check("t3_busy", bus.pr_ready, 0);
            tick();
        end
        check("t3_ready", bus.pr_ready, 1);
        check("t3_err", bus.pr_err, 1);
        check("t3_rd", bus.pr_rd, 0);
        check("t3_re_off", bus.dev_re, 0);
        bus.pr_re = 1'b0;
        tick();
        check("t3_pulse", bus.pr_ready, 0);
        check("t3_err_clr", bus.pr_err, 0);

        // Write dev 0 offset 0 with immediate ack.
        bus.pr_addr = 30'h1FC0;
        bus.pr_wd   = 32'hA5A5_A5A5;
        bus.pr_we   = 1'b1;
        tick();
        check("t2_we", bus.dev_we, 4'b0001);
        check("t2_wd", bus.dev_wd, 32'hA5A5_A5A5);
        check("t2_addr", bus.dev_addr, 0);
        check("t2_re", bus.dev_re, 0);
        bus.dev_ack = 4'b0001;
        tick();
        check("t2_ready", bus.pr_ready, 1);
        check("t2_err", bus.pr_err, 0);
        check("t2_we_off", bus.dev_we, 0);
        bus.dev_ack = '0;
        bus.pr_we   = 1'b0;
        tick();
        check("t2_pulse", bus.pr_ready, 0);

        // Miss read, then write to read-only STATUS.
        bus.pr_addr = 30'h1FE0;
        bus.pr_re   = 1'b1;
        tick();
        check("t4_miss_ready", bus.pr_ready, 1);
        check("t4_miss_err", bus.pr_err, 1);
        check("t4_miss_re", bus.dev_re, 0);
        check("t4_miss_we", bus.dev_we, 0);
        bus.pr_re = 1'b0;
        tick();
        bus.pr_addr = 30'h1FD1;
        bus.pr_wd   = 32'hFFFF_FFFF;
        bus.pr_we   = 1'b1;
        tick();
        check("t4_stw_ready", bus.pr_ready, 1);
        check("t4_stw_err", bus.pr_err, 1);
        check("t4_stw_we", bus.dev_we, 0);
        bus.pr_we = 1'b0;
        tick();

        // MASK write, interrupt latency, MASK and STATUS readback.
        bus.pr_addr = 30'h1FD0;
        bus.pr_wd   = 32'h0000_0005;
        bus.pr_we   = 1'b1;
        tick();
        check("t5_mw_ready", bus.pr_ready, 1);
        check("t5_mw_err", bus.pr_err, 0);
        bus.pr_we   = 1'b0;
        bus.dev_irq = 4'b1111;
        tick();
        check("t5_int_lag", bus.hw_int, 0);
        tick();
        check("t5_int", bus.hw_int, 4'b0101);
        bus.pr_re = 1'b1;
        tick();
        check("t5_mr_ready", bus.pr_ready, 1);
        check("t5_mr_rd", bus.pr_rd, 32'h0000_0005);
        bus.pr_addr = 30'h1FD1;
        tick();
        check("t5_done_ignores", bus.pr_ready, 0);
        tick();
        check("t5_st_ready", bus.pr_ready, 1);
        check("t5_st_rd", bus.pr_rd, 32'h0000_000F);
        check("t5_st_err", bus.pr_err, 0);
        bus.pr_re = 1'b0;
        tick();

        // Reset during a dev 3 read abandons it and clears MASK.
        bus.pr_addr = 30'h1FCC;
        bus.pr_re   = 1'b1;
        tick();
        check("t6_re", bus.dev_re, 4'b1000);
        tick();
        rst = 1'b1;
        tick();
        check("t6_re_drop", bus.dev_re, 0);
        check("t6_no_ready", bus.pr_ready, 0);
        check("t6_int_rst", bus.hw_int, 0);
        rst       = 1'b0;
        bus.pr_re = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_quiet", bus.pr_ready, 0);
            check("t6_masked", bus.hw_int, 0);
        end
        bus.dev_rd[127:96] = 32'hCAFE_F00D;
        bus.pr_re = 1'b1;
        tick();
        check("t6_post_re", bus.dev_re, 4'b1000);
        bus.dev_ack = 4'b1000;
        tick();
        check("t6_post_ready", bus.pr_ready, 1);
        check("t6_post_rd", bus.pr_rd, 32'hCAFE_F00D);
        check("t6_post_err", bus.pr_err, 0);
        bus.dev_ack = '0;
        bus.pr_re   = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_mdev.md
Name: bridge_mdev

Overview:
- Parametrised system bridge between the multicycle CPU's data port and NUM_DEV memory-mapped peripherals (timers, I/O), replacing the fixed single-timer bridge.
- Decodes the address into per-device windows and runs a request/ready handshake, with per-device wait states and a timeout.
- Registers read data, flags bus errors, and aggregates device interrupts under a software-visible mask.

Parameters:
- NUM_DEV, 4, number of device windows (1..8)
- BASE_ADDR, 32'h0000_7F00, byte address of window 0; 16-byte aligned or better
- OFF_W, 2, word-offset bits per window (window = 2**OFF_W words)
- TIMEOUT, 16, maximum WAIT cycles before an error completion (2..2**CNT_W-1)
- CNT_W, 5, width of the timeout counter

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- pr_addr  in  30  CPU word address [31:2]
- pr_wd  in  32  CPU write data
- pr_we  in  1  write request; held until pr_ready
- pr_re  in  1  read request; held until pr_ready
- pr_rd  out  32  registered read data; valid while pr_ready=1
- pr_ready  out  1  one-cycle completion pulse
- pr_err  out  1  error flag, valid with pr_ready
- dev_addr  out  OFF_W  latched word offset within the window
- dev_wd  out  32  latched write data, shared by all devices
- dev_we  out  NUM_DEV  one-hot write strobe
- dev_re  out  NUM_DEV  one-hot read strobe
- dev_rd  in  32*NUM_DEV  device read data, flattened; device i at [32i+31:32i]
- dev_ack  in  NUM_DEV  device completion, one cycle
- dev_irq  in  NUM_DEV  level interrupt requests
- hw_int  out  NUM_DEV  masked, registered interrupts to the CPU

Behaviour:
- Reset values:
  - state=IDLE.
  - pr_rd, dev_wd: 0.
  - pr_ready, pr_err, dev_we, dev_re, hw_int: 0.
  - dev_addr: 0.
  - mask register: 0.
  - irq_sync register: 0.
- Decode (combinational, IDLE only):
  - byte address A = {pr_addr,2'b00}.
  - Device i hits when A[31:OFF_W+2] == (BASE_ADDR>>(OFF_W+2)) + i, for i < NUM_DEV.
  - Control window hits at index NUM_DEV:
    - offset 0: MASK, read/write, low NUM_DEV bits.
    - offset 1: STATUS, read-only, irq_sync zero-extended.
    - other offsets: error.
- States IDLE, WAIT, DONE; encoding 2 bits.
- IDLE, no request: stay.
- IDLE, request (pr_we wins over pr_re if both are asserted):
  - Device hit: latch offset into dev_addr and pr_wd into dev_wd, latch the device index and op, clear the counter, go to WAIT.
  - Control hit: a write updates MASK this edge, a read loads pr_rd; go to DONE, err=0.
  - Miss, or a write to STATUS: pr_rd=0, err=1, go to DONE.
- WAIT:
  - dev_we/dev_re bit for the latched index is held high every WAIT cycle; all other bits are 0.
  - dev_ack of the selected device: capture its dev_rd into pr_rd (write ops capture 0), err=0, go to DONE.
  - Acks from non-selected devices are ignored.
  - Counter increments each WAIT cycle. If it reaches TIMEOUT-1 without an ack: pr_rd=0, err=1, go to DONE.
  - An ack in the same cycle as the timeout wins.
- DONE: pr_ready=1 and pr_err valid for exactly one cycle, then IDLE. Requests present in DONE are not sampled.
- Latency:
  - Control or miss access: request edge to pr_ready = 1 cycle.
  - Device access: 2 + (cycles until ack).
- The CPU may change pr_* only after pr_ready; the bridge never re-uses live pr_* after IDLE.
- Interrupts:
  - irq_sync <= dev_irq each cycle.
  - hw_int <= irq_sync & MASK, so hw_int lags dev_irq by 2 cycles.
  - A MASK write affects hw_int on the following edge.
- rst high in any state: next edge forces all reset values, abandoning any transfer. A device mid-access sees its strobe drop; no pr_ready is generated.

Decomposition:
- Shared include file holds:
  - state encodings S_IDLE=0, S_WAIT=1, S_DONE=2.
  - control offsets CTL_MASK=0, CTL_STATUS=1.
  - bus error data constant (32'h0).
- One sub-module, bridge_mdev_decode: purely combinational. Maps pr_addr to dev_hit[NUM_DEV:0], index and offset. Parametrised by NUM_DEV, BASE_ADDR, OFF_W.

Test Plan:
- Read dev 1 offset 2 (A=0x7F18); dev_ack[1] asserted 3 cycles into WAIT with dev_rd[63:32]=0x12345678 -> dev_re=4'b0010 for 3 cycles, dev_addr=2, then pr_ready pulse with pr_rd=0x12345678, pr_err=0.
- Write 0xA5A5A5A5 to dev 0 offset 0 (A=0x7F00), immediate ack -> dev_we=4'b0001 for 1 cycle, dev_wd=0xA5A5A5A5, pr_ready 2 cycles after request, pr_err=0.
- Read dev 2 (A=0x7F20), never ack, TIMEOUT=16 -> dev_re[2] high 16 cycles, then pr_ready with pr_err=1, pr_rd=0; next request accepted normally.
- Miss A=0x7F80 read; also a write to STATUS (A=0x7F44) -> pr_ready next cycle, pr_err=1, no dev_we/dev_re activity.
- Write MASK=4'b0101 (A=0x7F40); drive dev_irq=4'b1111 -> hw_int=4'b0101 two cycles later; reading STATUS returns 0x0000000F.
- Assert rst during WAIT of a dev 3 read -> next edge dev_re=0, pr_ready never pulses, MASK=0, hw_int=0; a post-reset request completes correctly.
